// File: rtl/id_stage_hazard_pkg.sv
// Shared types for the ID stage: forwarding source select and load-use hazard FSM states.
// Also holds the operand-source priority helper used by both read ports.
package id_stage_hazard_pkg;

  typedef enum logic [2:0] {
    FWD_ZERO,
    FWD_EX,
    FWD_MEM,
    FWD_WB,
    FWD_RF
  } fwd_src_e;

  typedef enum logic {
    HZ_IDLE,
    HZ_STALL
  } hz_state_e;

  localparam int MAX_LOAD_BUBBLES = 2;

  // Youngest producer wins; XZR overrides every producer.
  function automatic fwd_src_e fwd_pick(input logic is_zero, input logic ex_hit,
                                        input logic mem_hit, input logic wb_hit);
    if (is_zero)      return FWD_ZERO;
    else if (ex_hit)  return FWD_EX;
    else if (mem_hit) return FWD_MEM;
    else if (wb_hit)  return FWD_WB;
    else              return FWD_RF;
  endfunction

endpackage

// File: rtl/id_stage_hazard_regfile_wt.sv
// Architectural register file: two async reads, one sync write, write-through on reads,
// the zero register always reads 0 and silently drops writes.
module id_stage_hazard_regfile_wt #(
  parameter int DATA_W   = 64,
  parameter int NREG     = 32,
  parameter int ZERO_REG = 31,
  localparam int AW      = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     rd_addr_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (wr_en && wr_addr != ZR) regs_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    if (rd_addr_a == ZR)                     rd_data_a = '0;
    else if (wr_en && wr_addr == rd_addr_a)  rd_data_a = wr_data;
    else                                     rd_data_a = regs_q[rd_addr_a];
    if (rd_addr_b == ZR)                     rd_data_b = '0;
    else if (wr_en && wr_addr == rd_addr_b)  rd_data_b = wr_data;
    else                                     rd_data_b = regs_q[rd_addr_b];
  end

endmodule

// File: rtl/id_stage_hazard.sv
// Register-read/decode stage: operand forwarding from EX/MEM/WB, load-use stall FSM,
// branch squash, and the registered ID/EX bundle handed to the ALU stage.
module id_stage_hazard
  import id_stage_hazard_pkg::*;
#(
  parameter int DATA_W       = 64,
  parameter int NREG         = 32,
  parameter int ZERO_REG     = 31,
  parameter int CTRL_W       = 8,
  parameter int LOAD_BUBBLES = 1,
  localparam int AW          = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [AW-1:0]     in_ra,
  input  logic [AW-1:0]     in_rb,
  input  logic              in_use_a,
  input  logic              in_use_b,
  input  logic [AW-1:0]     in_rw,
  input  logic              in_wr_en,
  input  logic              in_is_load,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              flush,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall_out,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [AW-1:0]     ex_rw,
  output logic              ex_wr_en,
  output logic              ex_is_load
);

  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

  hz_state_e         state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              load_use, bubble;
  fwd_src_e          src_a, src_b;
  logic [DATA_W-1:0] rf_a, rf_b, fwd_a, fwd_b;

  logic              ex_valid_q, ex_valid_d, ex_wr_en_q, ex_wr_en_d, ex_is_load_q, ex_is_load_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [DATA_W-1:0] ex_op_a_q, ex_op_a_d, ex_op_b_q, ex_op_b_d, ex_store_q, ex_store_d;
  logic [AW-1:0]     ex_rw_q, ex_rw_d, mem_rw_q, mem_rw_d;
  logic              mem_valid_q, mem_valid_d, mem_wr_en_q, mem_wr_en_d;

  id_stage_hazard_regfile_wt #(
    .DATA_W(DATA_W), .NREG(NREG), .ZERO_REG(ZERO_REG)
  ) u_regfile (
    .clk(clk), .reset(reset),
    .rd_addr_a(in_ra), .rd_addr_b(in_rb),
    .rd_data_a(rf_a), .rd_data_b(rf_b),
    .wr_en(wb_en), .wr_addr(wb_addr), .wr_data(wb_data)
  );

  // A load in EX cannot forward its data yet, so it never counts as an EX hit.
  always_comb begin
    src_a = fwd_pick(in_ra == ZR,
                     ex_valid_q && ex_wr_en_q && !ex_is_load_q && ex_rw_q == in_ra,
                     mem_valid_q && mem_wr_en_q && mem_rw_q == in_ra,
                     wb_en && wb_addr == in_ra);
    src_b = fwd_pick(in_rb == ZR,
                     ex_valid_q && ex_wr_en_q && !ex_is_load_q && ex_rw_q == in_rb,
                     mem_valid_q && mem_wr_en_q && mem_rw_q == in_rb,
                     wb_en && wb_addr == in_rb);
    case (src_a)
      FWD_EX:  fwd_a = ex_result;
      FWD_MEM: fwd_a = mem_result;
      FWD_WB:  fwd_a = wb_data;
      FWD_RF:  fwd_a = rf_a;
      default: fwd_a = '0;
    endcase
    case (src_b)
      FWD_EX:  fwd_b = ex_result;
      FWD_MEM: fwd_b = mem_result;
      FWD_WB:  fwd_b = wb_data;
      FWD_RF:  fwd_b = rf_b;
      default: fwd_b = '0;
    endcase
  end

  assign load_use = in_valid && ex_valid_q && ex_is_load_q && ex_wr_en_q && ex_rw_q != ZR &&
                    ((in_use_a && in_ra == ex_rw_q) || (in_use_b && in_rb == ex_rw_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HZ_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The hazard cycle itself is the first bubble; STALL covers any extra ones.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      HZ_IDLE: begin
        if (load_use && !flush && LOAD_BUBBLES > 1) begin
          state_d = HZ_STALL;
          cnt_d   = 2'(LOAD_BUBBLES - 1);
        end
      end
      HZ_STALL: begin
        if (flush || cnt_q <= 2'd1) begin
          state_d = HZ_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
    endcase
  end

  always_comb begin
    stall_out = !flush && (state_q == HZ_STALL || load_use);
    bubble    = flush || stall_out || !in_valid;
  end

  always_comb begin
    ex_valid_d   = !bubble;
    ex_wr_en_d   = !bubble && in_wr_en;
    ex_is_load_d = !bubble && in_is_load;
    ex_ctrl_d    = in_ctrl;
    ex_op_a_d    = fwd_a;
    ex_op_b_d    = in_use_imm ? in_imm : fwd_b;
    ex_store_d   = fwd_b;
    ex_rw_d      = in_rw;
    mem_valid_d  = ex_valid_q;
    mem_wr_en_d  = ex_wr_en_q;
    mem_rw_d     = ex_rw_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q   <= 1'b0;
      ex_wr_en_q   <= 1'b0;
      ex_is_load_q <= 1'b0;
      ex_ctrl_q    <= '0;
      ex_op_a_q    <= '0;
      ex_op_b_q    <= '0;
      ex_store_q   <= '0;
      ex_rw_q      <= '0;
      mem_valid_q  <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      mem_rw_q     <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_wr_en_q   <= ex_wr_en_d;
      ex_is_load_q <= ex_is_load_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_op_a_q    <= ex_op_a_d;
      ex_op_b_q    <= ex_op_b_d;
      ex_store_q   <= ex_store_d;
      ex_rw_q      <= ex_rw_d;
      mem_valid_q  <= mem_valid_d;
      mem_wr_en_q  <= mem_wr_en_d;
      mem_rw_q     <= mem_rw_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_ctrl       = ex_ctrl_q;
  assign ex_op_a       = ex_op_a_q;
  assign ex_op_b       = ex_op_b_q;
  assign ex_store_data = ex_store_q;
  assign ex_rw         = ex_rw_q;
  assign ex_wr_en      = ex_wr_en_q;
  assign ex_is_load    = ex_is_load_q;

endmodule

// File: tb/tb_id_stage_hazard.sv
// Bench for id_stage_hazard: a one-bubble and a two-bubble instance share stimulus;
// table vectors, directed hazard/forwarding sequences, then random traffic against a reference model.
module tb_id_stage_hazard;

  logic        clk, reset;
  logic        in_valid, in_use_a, in_use_b, in_wr_en, in_is_load, in_use_imm, flush, wb_en;
  logic [7:0]  in_ctrl;
  logic [4:0]  in_ra, in_rb, in_rw, wb_addr;
  logic [63:0] in_imm, ex_result, mem_result, wb_data;

  logic        d1_stall, d1_valid, d1_wr_en, d1_is_load;
  logic [7:0]  d1_ctrl;
  logic [63:0] d1_op_a, d1_op_b, d1_store;
  logic [4:0]  d1_rw;
  logic        d2_stall, d2_valid, d2_wr_en, d2_is_load;
  logic [7:0]  d2_ctrl;
  logic [63:0] d2_op_a, d2_op_b, d2_store;
  logic [4:0]  d2_rw;

  int passed = 0;
  int total  = 0;

  id_stage_hazard #(.LOAD_BUBBLES(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_ra(in_ra), .in_rb(in_rb),
    .in_use_a(in_use_a), .in_use_b(in_use_b), .in_rw(in_rw), .in_wr_en(in_wr_en),
    .in_is_load(in_is_load), .in_use_imm(in_use_imm), .in_imm(in_imm), .flush(flush),
    .ex_result(ex_result), .mem_result(mem_result), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .stall_out(d1_stall), .ex_valid(d1_valid), .ex_ctrl(d1_ctrl),
    .ex_op_a(d1_op_a), .ex_op_b(d1_op_b), .ex_store_data(d1_store), .ex_rw(d1_rw),
    .ex_wr_en(d1_wr_en), .ex_is_load(d1_is_load)
  );

  id_stage_hazard #(.LOAD_BUBBLES(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_ra(in_ra), .in_rb(in_rb),
    .in_use_a(in_use_a), .in_use_b(in_use_b), .in_rw(in_rw), .in_wr_en(in_wr_en),
    .in_is_load(in_is_load), .in_use_imm(in_use_imm), .in_imm(in_imm), .flush(flush),
    .ex_result(ex_result), .mem_result(mem_result), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .stall_out(d2_stall), .ex_valid(d2_valid), .ex_ctrl(d2_ctrl),
    .ex_op_a(d2_op_a), .ex_op_b(d2_op_b), .ex_store_data(d2_store), .ex_rw(d2_rw),
    .ex_wr_en(d2_wr_en), .ex_is_load(d2_is_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic [4:0]  ra, rb;
    logic        use_imm;
    logic [63:0] imm;
    logic [63:0] exp_a, exp_b, exp_st;
  } vec_t;

  vec_t vecs [6];

  // Reference model state: the two instructions ahead of ID, architectural registers, stalls left.
  typedef struct {
    logic       valid, wr, ld;
    logic [4:0] rw;
  } tag_t;

  tag_t        m_ex, m_mem;
  logic [63:0] m_rf [32];
  int          stall_left;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [4:0] ra, input logic [4:0] rb,
                               input logic use_a, input logic use_b, input logic [4:0] rw,
                               input logic wr_en, input logic is_load);
    in_valid   = valid;
    in_ra      = ra;
    in_rb      = rb;
    in_use_a   = use_a;
    in_use_b   = use_b;
    in_rw      = rw;
    in_wr_en   = wr_en;
    in_is_load = is_load;
    in_ctrl    = 8'h00;
    in_use_imm = 1'b0;
    in_imm     = '0;
    flush      = 1'b0;
    wb_en      = 1'b0;
    wb_addr    = '0;
    wb_data    = '0;
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  function automatic logic [4:0] pick();
    case ($urandom_range(0, 3))
      0:       return 5'd1;
      1:       return 5'd2;
      2:       return 5'd3;
      default: return 5'd31;
    endcase
  endfunction

  function automatic logic [63:0] model_src(input logic [4:0] s);
    if (s == 5'd31) return '0;
    if (m_ex.valid && m_ex.wr && !m_ex.ld && m_ex.rw == s) return ex_result;
    if (m_mem.valid && m_mem.wr && m_mem.rw == s) return mem_result;
    if (wb_en && wb_addr == s) return wb_data;
    return m_rf[s];
  endfunction

  initial begin
    logic        haz, exp_stall, bub;
    logic [63:0] e_a, e_b, e_st;
    tag_t        e_tag;
    logic [7:0]  e_ctrl;

    vecs[0] = '{1'b1, 5'd5,  64'd50, 5'd5,  5'd31, 1'b0, 64'd0,   64'd50, 64'd0,   64'd0};
    vecs[1] = '{1'b0, 5'd0,  64'd0,  5'd5,  5'd6,  1'b0, 64'd0,   64'd50, 64'd0,   64'd0};
    vecs[2] = '{1'b1, 5'd6,  64'd7,  5'd6,  5'd5,  1'b0, 64'd0,   64'd7,  64'd50,  64'd50};
    vecs[3] = '{1'b1, 5'd31, 64'd77, 5'd31, 5'd6,  1'b0, 64'd0,   64'd0,  64'd7,   64'd7};
    vecs[4] = '{1'b0, 5'd0,  64'd0,  5'd31, 5'd5,  1'b1, 64'd123, 64'd0,  64'd123, 64'd50};
    vecs[5] = '{1'b1, 5'd5,  64'd9,  5'd5,  5'd5,  1'b0, 64'd0,   64'd9,  64'd9,   64'd9};

    ex_result  = '0;
    mem_result = '0;

    // Reset with a read of X1 pending, then issue it.
    applyStimulus(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("reset_ex_valid", d1_valid, 1'b0);
    checkOutput("reset_stall", d1_stall, 1'b0);
    checkOutput("reset_ex_wr_en", d1_wr_en, 1'b0);
    step();
    checkOutput("post_reset_valid", d1_valid, 1'b1);
    checkOutput("post_reset_op_a", d1_op_a, 64'd0);

    // Write-through and regfile reads, immediate select, XZR write drop.
    resetDut();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, vecs[i].ra, vecs[i].rb, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
      wb_en      = vecs[i].wb_en;
      wb_addr    = vecs[i].wb_addr;
      wb_data    = vecs[i].wb_data;
      in_use_imm = vecs[i].use_imm;
      in_imm     = vecs[i].imm;
      step();
      checkOutput($sformatf("vec%0d_valid", i), d1_valid, 1'b1);
      checkOutput($sformatf("vec%0d_op_a", i), d1_op_a, vecs[i].exp_a);
      checkOutput($sformatf("vec%0d_op_b", i), d1_op_b, vecs[i].exp_b);
      checkOutput($sformatf("vec%0d_store", i), d1_store, vecs[i].exp_st);
    end

    // EX beats MEM, then MEM alone.
    resetDut();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
    step();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
    step();
    applyStimulus(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    ex_result  = 64'd8;
    mem_result = 64'd99;
    step();
    checkOutput("ex_priority_op_a", d1_op_a, 64'd8);
    applyStimulus(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    step();
    checkOutput("mem_fwd_op_a", d1_op_a, 64'd99);

    // Load-use, one bubble, data from MEM.
    resetDut();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1);
    step();
    applyStimulus(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checkOutput("lu1_stall", d1_stall, 1'b1);
    step();
    checkOutput("lu1_bubble", d1_valid, 1'b0);
    mem_result = 64'd42;
    #1;
    checkOutput("lu1_stall_release", d1_stall, 1'b0);
    step();
    checkOutput("lu1_issue_valid", d1_valid, 1'b1);
    checkOutput("lu1_op_a", d1_op_a, 64'd42);

    // Load-use, two bubbles, flushed in the second stall cycle.
    resetDut();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1);
    step();
    applyStimulus(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checkOutput("lu2f_stall1", d2_stall, 1'b1);
    step();
    checkOutput("lu2f_bubble1", d2_valid, 1'b0);
    checkOutput("lu2f_stall2", d2_stall, 1'b1);
    flush = 1'b1;
    #1;
    checkOutput("lu2f_flush_stall", d2_stall, 1'b0);
    step();
    checkOutput("lu2f_flush_valid", d2_valid, 1'b0);
    applyStimulus(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    checkOutput("lu2f_idle_stall", d2_stall, 1'b0);
    step();
    checkOutput("lu2f_idle_issue", d2_valid, 1'b1);

    // Load-use, two bubbles, data from write-back.
    resetDut();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1);
    step();
    applyStimulus(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    step();
    checkOutput("lu2_bubble1", d2_valid, 1'b0);
    checkOutput("lu2_stall2", d2_stall, 1'b1);
    step();
    checkOutput("lu2_bubble2", d2_valid, 1'b0);
    checkOutput("lu2_release", d2_stall, 1'b0);
    wb_en   = 1'b1;
    wb_addr = 5'd3;
    wb_data = 64'd42;
    step();
    checkOutput("lu2_issue_valid", d2_valid, 1'b1);
    checkOutput("lu2_op_a", d2_op_a, 64'd42);

    // XZR ignores both write-back and an EX producer targeting it.
    resetDut();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd31, 1'b1, 1'b0);
    wb_en = 1'b1; wb_addr = 5'd31; wb_data = 64'd77;
    step();
    applyStimulus(1'b1, 5'd31, 5'd31, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    wb_en = 1'b1; wb_addr = 5'd31; wb_data = 64'd77;
    ex_result = 64'd5;
    step();
    checkOutput("xzr_op_a", d1_op_a, 64'd0);
    checkOutput("xzr_op_b", d1_op_b, 64'd0);

    // Random traffic on the one-bubble instance.
    resetDut();
    m_ex       = '{1'b0, 1'b0, 1'b0, 5'd0};
    m_mem      = '{1'b0, 1'b0, 1'b0, 5'd0};
    stall_left = 0;
    for (int r = 0; r < 32; r++) m_rf[r] = '0;
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 7) != 0, pick(), pick(), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), pick(), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2) == 0);
      in_ctrl    = 8'($urandom);
      in_use_imm = 1'($urandom_range(0, 1));
      in_imm     = {$urandom, $urandom};
      flush      = $urandom_range(0, 9) == 0;
      ex_result  = {$urandom, $urandom};
      mem_result = {$urandom, $urandom};
      wb_en      = 1'($urandom_range(0, 1));
      wb_addr    = pick();
      wb_data    = {$urandom, $urandom};
      #1;
      haz = in_valid && m_ex.valid && m_ex.ld && m_ex.wr && m_ex.rw != 5'd31 &&
            ((in_use_a && in_ra == m_ex.rw) || (in_use_b && in_rb == m_ex.rw));
      exp_stall = !flush && (stall_left > 0 || haz);
      checkOutput("rnd_stall", d1_stall, exp_stall);
      bub    = flush || exp_stall || !in_valid;
      e_a    = model_src(in_ra);
      e_st   = model_src(in_rb);
      e_b    = in_use_imm ? in_imm : e_st;
      e_ctrl = in_ctrl;
      e_tag  = '{!bub, !bub && in_wr_en, !bub && in_is_load, in_rw};
      if (flush)               stall_left = 0;
      else if (stall_left > 0) stall_left = stall_left - 1;
      else if (haz)            stall_left = 0;
      if (wb_en && wb_addr != 5'd31) m_rf[wb_addr] = wb_data;
      m_mem = m_ex;
      m_ex  = e_tag;
      step();
      checkOutput("rnd_valid", d1_valid, e_tag.valid);
      checkOutput("rnd_wr_en", d1_wr_en, e_tag.wr);
      checkOutput("rnd_is_load", d1_is_load, e_tag.ld);
      if (e_tag.valid) begin
        checkOutput("rnd_rw", d1_rw, e_tag.rw);
        checkOutput("rnd_ctrl", d1_ctrl, e_ctrl);
        checkOutput("rnd_op_a", d1_op_a, e_a);
        checkOutput("rnd_op_b", d1_op_b, e_b);
        checkOutput("rnd_store", d1_store, e_st);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
